// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one 32-bit ALU (ALU_32_bits, ALU_Op[3:0], flags {V,C,Z,N}) between
//   NREQ requesters. Each operation is sequenced accept -> execute -> respond.
//   The requester that is granted owns the ALU until its response has been
//   accepted. Grants rotate round-robin.
//
// Handshake rules (valid/ready, both directions):
//   A transfer happens on a rising clock edge where valid and ready are both 1.
//   The source holds valid and its payload stable until that edge. The sink may
//   raise ready at any time, and ready may depend combinationally on valid.
//   - Request side:  req_valid[i] + req_op/req_a/req_b slices -> req_ready[i].
//     req_ready is one-hot and is only ever set in IDLE.
//   - Response side: rsp_valid[owner] + rsp_result/rsp_flags/rsp_err ->
//     rsp_ready[owner]. rsp_ready of non-owners is ignored.
//
// Ports
//   clk, rst_n          clock (rising edge) and async active-low reset
//   req_valid/ready     per-requester request handshake (NREQ bits)
//   req_op/a/b          packed per-requester opcode (4b) and operands (32b)
//   rsp_valid/ready     per-requester response handshake (NREQ bits)
//   rsp_result/flags    captured ALU result and {V,C,Z,N}
//   rsp_err             opcode rejected (only when ALU_ARB_OPCHECK_EN)
//   alu_a/b/op          registered drive to the shared ALU
//   alu_result/flags    combinational return from the shared ALU
//   busy                1 whenever the FSM is not in IDLE
//
// Configuration macro: ALU_ARB_OPCHECK_EN
//   Defined: only opcodes 0..7, 4'hB, 4'hC reach the ALU. Any other opcode is
//   still granted, but it bypasses EXEC. It is answered one cycle after accept
//   with result 0, flags 0, rsp_err 1, and the ALU pins are left untouched.
//   Undefined: every opcode goes to the ALU, and rsp_err is tied to 0.
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_result,
  output logic [3:0]           rsp_flags,
  output logic                 rsp_err,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [3:0]           alu_op,
  input  logic [31:0]          alu_result,
  input  logic [3:0]           alu_flags,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;

  // Grant search: the first valid index starting at rr_ptr, wrapping mod NREQ.
  logic             gnt_found;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] gnt_next;
  int unsigned      pos;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    pos       = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!gnt_found && req_valid[pos]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(pos);
      end
    end
  end

  // After a grant, the requester just served drops to the lowest priority.
  assign gnt_next = (gnt_idx == IDX_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

  logic [3:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;

  assign sel_op = req_op[gnt_idx*4 +: 4];
  assign sel_a  = req_a[gnt_idx*32 +: 32];
  assign sel_b  = req_b[gnt_idx*32 +: 32];

  // The accept pulse is combinational so the requester sees it in the grant
  // cycle. It is gated by rst_n so that every output reads 0 during reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && gnt_found) req_ready = ONE_HOT0 << gnt_idx;
  end

  assign busy = (state != IDLE);

`ifdef ALU_ARB_OPCHECK_EN
  logic op_legal;
  logic err_q;

  assign op_legal = (sel_op <= 4'h7) || (sel_op == 4'hB) || (sel_op == 4'hC);
  assign rsp_err  = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_valid  <= '0;
`ifdef ALU_ARB_OPCHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            owner  <= gnt_idx;
            rr_ptr <= gnt_next;
`ifdef ALU_ARB_OPCHECK_EN
            if (!op_legal) begin
              // Rejected op: the ALU pins keep their previous values.
              rsp_result <= '0;
              rsp_flags  <= '0;
              err_q      <= 1'b1;
              rsp_valid  <= ONE_HOT0 << gnt_idx;
              state      <= RESP;
            end else begin
              alu_a  <= sel_a;
              alu_b  <= sel_b;
              alu_op <= sel_op;
              state  <= EXEC;
            end
`else
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            alu_op <= sel_op;
            state  <= EXEC;
`endif
          end
        end
        EXEC: begin
          // The ALU has had the whole cycle to settle on the registered pins.
          rsp_result <= alu_result;
          rsp_flags  <= alu_flags;
          rsp_valid  <= ONE_HOT0 << owner;
`ifdef ALU_ARB_OPCHECK_EN
          err_q      <= 1'b0;
`endif
          state      <= RESP;
        end
        RESP: begin
          // Return through IDLE, so no grant is made in the completing cycle.
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Directed bench for alu_share_arbiter (NREQ=4) with a small behavioural
//   stand-in for ALU_32_bits that covers ADD (4'h3) and SUB (4'hB). Every other
//   opcode returns 0. Inputs change on the falling edge, and outputs are
//   sampled on the falling edge or shortly after it.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

  localparam int NREQ = 4;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [4*NREQ-1:0]    req_op;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [31:0]          rsp_result;
  logic [3:0]           rsp_flags;
  logic                 rsp_err;
  logic [31:0]          alu_a;
  logic [31:0]          alu_b;
  logic [3:0]           alu_op;
  logic [31:0]          alu_result;
  logic [3:0]           alu_flags;
  logic                 busy;

  int checks;
  int errors;

  alu_share_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .busy       (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in: flags are {V,C,Z,N}
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum    = '0;
    alu_result = '0;
    alu_flags  = '0;
    case (alu_op)
      4'h3: begin
        alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = alu_sum[31:0];
        alu_flags  = {(alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]),
                      alu_sum[32], alu_sum[31:0] == 32'd0, alu_sum[31]};
      end
      4'hB: begin
        alu_sum    = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_result = alu_sum[31:0];
        alu_flags  = {(alu_a[31] != alu_b[31]) && (alu_sum[31] != alu_a[31]),
                      alu_sum[32], alu_sum[31:0] == 32'd0, alu_sum[31]};
      end
      default: begin
        alu_result = '0;
        alu_flags  = '0;
      end
    endcase
  end

  // driver tasks
  task automatic set_req(input int i, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_op[i*4 +: 4]   = op;
    req_a[i*32 +: 32]  = a;
    req_b[i*32 +: 32]  = b;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, busy, rsp_err} !== 10'd0) begin
      errors++;
      $display("FAIL reset_ctrl got ready=%b rsp_valid=%b busy=%b err=%b exp all 0",
               req_ready, rsp_valid, busy, rsp_err);
    end
    checks++;
    if ({alu_a, alu_b, alu_op} !== 68'd0) begin
      errors++;
      $display("FAIL reset_alu_pins got a=%h b=%h op=%h exp 0", alu_a, alu_b, alu_op);
    end
    checks++;
    if ({rsp_result, rsp_flags} !== 36'd0) begin
      errors++;
      $display("FAIL reset_rsp got result=%h flags=%b exp 0", rsp_result, rsp_flags);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_idle got busy=%b ready=%b exp 0/0000", busy, req_ready);
    end
  endtask

  task automatic test_single_op;
    set_req(0, 4'h3, 32'd5, 32'd7);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant got %b exp 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (alu_op !== 4'h3 || alu_a !== 32'd5 || alu_b !== 32'd7 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_exec got op=%h a=%h b=%h busy=%b exp 3/5/7/1",
               alu_op, alu_a, alu_b, busy);
    end
    checks++;
    if (rsp_valid !== 4'b0000 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_exec_quiet got rsp_valid=%b ready=%b exp 0000/0000",
               rsp_valid, req_ready);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_result !== 32'd12 || rsp_flags !== 4'b0000 ||
        rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_resp got v=%b r=%h f=%b e=%b exp 0001/0000000c/0000/0",
               rsp_valid, rsp_result, rsp_flags, rsp_err);
    end
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '0;
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done got rsp_valid=%b busy=%b exp 0000/0", rsp_valid, busy);
    end
  endtask

  task automatic test_sub_zero_hold;
    set_req(1, 4'hB, 32'd9, 32'd9);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL sub_grant got %b exp 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    // a non-owner's ready has to be ignored
    rsp_ready = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 4'b0010 || rsp_result !== 32'd0 || rsp_flags !== 4'b0110) begin
        errors++;
        $display("FAIL sub_hold[%0d] got v=%b r=%h f=%b exp 0010/00000000/0110",
                 i, rsp_valid, rsp_result, rsp_flags);
      end
      @(negedge clk);
    end
    rsp_ready = 4'b0010;
    @(negedge clk);
    rsp_ready = '0;
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL sub_done got %b exp 0000", rsp_valid);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_oh;
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 4'h3, 32'd100 + 32'(i), 32'(i));
    req_valid = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 5; r++) begin
      exp_oh = 4'b0001 << (r % 4);
      #1;
      checks++;
      if (req_ready !== exp_oh) begin
        errors++;
        $display("FAIL rr_grant[%0d] got %b exp %b", r, req_ready, exp_oh);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== exp_oh || rsp_result !== 32'd100 + 32'(2 * (r % 4))) begin
        errors++;
        $display("FAIL rr_resp[%0d] got v=%b r=%0d exp %b/%0d",
                 r, rsp_valid, rsp_result, exp_oh, 100 + 2 * (r % 4));
      end
      rsp_ready = exp_oh;
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL rr_no_grant_on_done[%0d] got %b exp 0000", r, req_ready);
      end
      @(negedge clk);
      rsp_ready = '0;
    end
    req_valid = '0;
  endtask

  task automatic test_overflow;
    set_req(2, 4'h3, 32'h7FFF_FFFF, 32'd1);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL ovf_grant got %b exp 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_result !== 32'h8000_0000 || rsp_flags !== 4'b1001) begin
      errors++;
      $display("FAIL ovf_resp got v=%b r=%h f=%b exp 0100/80000000/1001",
               rsp_valid, rsp_result, rsp_flags);
    end
    rsp_ready = 4'b0100;
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_reset_mid_op;
    set_req(2, 4'h3, 32'h11, 32'h22);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (busy !== 1'b1 || alu_a !== 32'h11) begin
      errors++;
      $display("FAIL midrst_exec got busy=%b a=%h exp 1/00000011", busy, alu_a);
    end
    rst_n = 1'b0;
    set_req(1, 4'h3, 32'd1, 32'd2);
    req_valid = 4'b1010;
    #1;
    checks++;
    if ({busy, rsp_valid, req_ready, alu_a, alu_op, rsp_result} !== 77'd0) begin
      errors++;
      $display("FAIL midrst_outputs got busy=%b v=%b rdy=%b a=%h op=%h r=%h exp 0",
               busy, rsp_valid, req_ready, alu_a, alu_op, rsp_result);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_no_resp got %b exp 0000", rsp_valid);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL midrst_first_grant got %b exp 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_result !== 32'd3) begin
      errors++;
      $display("FAIL midrst_resp got v=%b r=%h exp 0010/00000003", rsp_valid, rsp_result);
    end
    rsp_ready = 4'b0010;
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_opcode;
    set_req(0, 4'hD, 32'hAA, 32'hBB);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL opc_grant got %b exp 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
`ifdef ALU_ARB_OPCHECK_EN
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_err !== 1'b1 || rsp_result !== 32'd0 ||
        rsp_flags !== 4'b0000) begin
      errors++;
      $display("FAIL opc_reject got v=%b e=%b r=%h f=%b exp 0001/1/0/0000",
               rsp_valid, rsp_err, rsp_result, rsp_flags);
    end
    checks++;
    if (alu_op !== 4'h3 || alu_a !== 32'd1 || alu_b !== 32'd2) begin
      errors++;
      $display("FAIL opc_alu_hold got op=%h a=%h b=%h exp 3/1/2", alu_op, alu_a, alu_b);
    end
`else
    checks++;
    if (alu_op !== 4'hD || alu_a !== 32'hAA || rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL opc_exec got op=%h a=%h v=%b exp d/aa/0000", alu_op, alu_a, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_result !== 32'd0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL opc_resp got v=%b r=%h e=%b exp 0001/0/0", rsp_valid, rsp_result, rsp_err);
    end
`endif
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '0;
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL opc_done got v=%b busy=%b exp 0000/0", rsp_valid, busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_op();
    test_sub_zero_hold();
    test_round_robin();
    test_overflow();
    test_reset_mid_op();
    test_opcode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
